muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit on the execute side of the datapath.
//  - Consumes the two register-file read operands (readData1/readData2) and the destination register.
//  - Returns one result plus a write-enable pulse that drives the register file write port
//    (regWrite/writeReg/writeData) on the following posedge.
//  - One operation in flight at a time; fixed latency for every op.

---
 rtl/muldiv_unit.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. One operation in flight at a time,
// fixed latency for every op: a radix-2 shift-add multiplier and a restoring
// shift-subtract divider share one pair of accumulator registers. Operands
// are reduced to magnitudes on acceptance, and the sign is put back in a
// short FIX phase before the result is registered for the write-back port.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [4:0]      rdIn,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdOut
);

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_BIT = 6'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negate when neg is set (single word)
    function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negate when neg is set (double word product)
    function automatic logic [2*XLEN-1:0] condNegWide(input logic [2*XLEN-1:0] v, input logic neg);
        logic [2*XLEN-1:0] r;
        if (neg) begin
            r = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Control state
    state_t          state_r;
    logic [5:0]      count_r;
    logic            fixPhase_r;
    logic            busy_r;
    logic            done_r;

    // Latched request
    logic [2:0]      op_r;
    logic [XLEN-1:0] opA_r;
    logic [4:0]      rd_r;
    logic            aNeg_r;
    logic            bNeg_r;
    logic            bZero_r;
    logic            ovf_r;

    // Datapath: hiAcc/loAcc hold the running product (mul) or remainder/quotient (div)
    logic [XLEN-1:0]   operand_r;
    logic [XLEN-1:0]   hiAcc_r;
    logic [XLEN-1:0]   loAcc_r;
    logic [2*XLEN-1:0] fix_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        rdOut_r;

    // Combinational helpers
    logic              accept_s;
    logic              aSignedIn_s;
    logic              bSignedIn_s;
    logic              aNegIn_s;
    logic              bNegIn_s;
    logic [XLEN-1:0]   aMagIn_s;
    logic [XLEN-1:0]   bMagIn_s;
    logic [XLEN:0]     mulSum_s;
    logic [XLEN:0]     divTrial_s;
    logic [XLEN:0]     divDiff_s;
    logic              divGe_s;
    logic [2*XLEN-1:0] fixNext_s;
    logic [XLEN-1:0]   resultSel_s;

    // Accept a new request in IDLE or in the DONE cycle, unless a flush is present
    always_comb begin
        accept_s = 1'b0;
        if (((state_r == IDLE) || (state_r == DONE)) && start && !abort) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Decode operand signedness from funct3 and form operand magnitudes
    always_comb begin
        aSignedIn_s = 1'b0;
        bSignedIn_s = 1'b0;
        case (op)
            OP_MULH: begin
                aSignedIn_s = 1'b1;
                bSignedIn_s = 1'b1;
            end
            OP_MULHSU: begin
                aSignedIn_s = 1'b1;
                bSignedIn_s = 1'b0;
            end
            OP_DIV, OP_REM: begin
                aSignedIn_s = 1'b1;
                bSignedIn_s = 1'b1;
            end
            default: begin
                aSignedIn_s = 1'b0;
                bSignedIn_s = 1'b0;
            end
        endcase
        aNegIn_s = aSignedIn_s & opA[XLEN-1];
        bNegIn_s = bSignedIn_s & opB[XLEN-1];
        aMagIn_s = condNeg(opA, aNegIn_s);
        bMagIn_s = condNeg(opB, bNegIn_s);
    end

    // One iteration step for both the multiplier and the restoring divider
    always_comb begin
        if (loAcc_r[0]) begin
            mulSum_s = {1'b0, hiAcc_r} + {1'b0, operand_r};
        end else begin
            mulSum_s = {1'b0, hiAcc_r};
        end
        divTrial_s = {hiAcc_r, loAcc_r[XLEN-1]};
        divDiff_s  = divTrial_s - {1'b0, operand_r};
        divGe_s    = ~divDiff_s[XLEN];
    end

    // Sign correction of the raw magnitudes; divide packs {remainder, quotient}
    always_comb begin
        if (op_r[2]) begin
            fixNext_s = {condNeg(hiAcc_r, aNeg_r), condNeg(loAcc_r, aNeg_r ^ bNeg_r)};
        end else begin
            fixNext_s = condNegWide({hiAcc_r, loAcc_r}, aNeg_r ^ bNeg_r);
        end
    end

    // Final result select with divide-by-zero and signed-overflow overrides
    always_comb begin
        resultSel_s = fix_r[XLEN-1:0];
        case (op_r)
            OP_MUL: begin
                resultSel_s = fix_r[XLEN-1:0];
            end
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                resultSel_s = fix_r[2*XLEN-1:XLEN];
            end
            OP_DIV: begin
                if (bZero_r) begin
                    resultSel_s = ALL_ONES;
                end else if (ovf_r) begin
                    resultSel_s = MIN_NEG;
                end else begin
                    resultSel_s = fix_r[XLEN-1:0];
                end
            end
            OP_DIVU: begin
                if (bZero_r) begin
                    resultSel_s = ALL_ONES;
                end else begin
                    resultSel_s = fix_r[XLEN-1:0];
                end
            end
            OP_REM: begin
                if (bZero_r) begin
                    resultSel_s = opA_r;
                end else if (ovf_r) begin
                    resultSel_s = {XLEN{1'b0}};
                end else begin
                    resultSel_s = fix_r[2*XLEN-1:XLEN];
                end
            end
            OP_REMU: begin
                if (bZero_r) begin
                    resultSel_s = opA_r;
                end else begin
                    resultSel_s = fix_r[2*XLEN-1:XLEN];
                end
            end
            default: begin
                resultSel_s = fix_r[XLEN-1:0];
            end
        endcase
    end

    // Control FSM: IDLE -> CALC (XLEN steps) -> FIX (sign, then select) -> DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            count_r    <= 6'd0;
            fixPhase_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r     <= 1'b0;
                    count_r    <= 6'd0;
                    fixPhase_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    done_r <= 1'b0;
                    if (abort) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        count_r <= 6'd0;
                    end else if (count_r == LAST_BIT) begin
                        state_r    <= FIX;
                        count_r    <= 6'd0;
                        fixPhase_r <= 1'b0;
                    end else begin
                        count_r <= count_r + 6'd1;
                    end
                end
                FIX: begin
                    if (abort) begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b0;
                        fixPhase_r <= 1'b0;
                    end else if (!fixPhase_r) begin
                        fixPhase_r <= 1'b1;
                    end else begin
                        state_r    <= DONE;
                        done_r     <= 1'b1;
                        fixPhase_r <= 1'b0;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    count_r <= 6'd0;
                    if (accept_s) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    count_r    <= 6'd0;
                    fixPhase_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch request, iterate, sign-correct, then register the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 3'd0;
            opA_r     <= {XLEN{1'b0}};
            rd_r      <= 5'd0;
            aNeg_r    <= 1'b0;
            bNeg_r    <= 1'b0;
            bZero_r   <= 1'b0;
            ovf_r     <= 1'b0;
            operand_r <= {XLEN{1'b0}};
            hiAcc_r   <= {XLEN{1'b0}};
            loAcc_r   <= {XLEN{1'b0}};
            fix_r     <= {(2*XLEN){1'b0}};
            result_r  <= {XLEN{1'b0}};
            rdOut_r   <= 5'd0;
        end else if (accept_s) begin
            op_r      <= op;
            opA_r     <= opA;
            rd_r      <= rdIn;
            aNeg_r    <= aNegIn_s;
            bNeg_r    <= bNegIn_s;
            bZero_r   <= (opB == {XLEN{1'b0}});
            ovf_r     <= (opA == MIN_NEG) && (opB == ALL_ONES);
            hiAcc_r   <= {XLEN{1'b0}};
            // Divide: loAcc shifts the dividend out while quotient bits shift in
            loAcc_r   <= op[2] ? aMagIn_s : bMagIn_s;
            operand_r <= op[2] ? bMagIn_s : aMagIn_s;
        end else if ((state_r == CALC) && !abort) begin
            if (op_r[2]) begin
                hiAcc_r <= divGe_s ? divDiff_s[XLEN-1:0] : divTrial_s[XLEN-1:0];
                loAcc_r <= {loAcc_r[XLEN-2:0], divGe_s};
            end else begin
                hiAcc_r <= mulSum_s[XLEN:1];
                loAcc_r <= {mulSum_s[0], loAcc_r[XLEN-1:1]};
            end
        end else if ((state_r == FIX) && !abort && !fixPhase_r) begin
            // Wide negation is registered on its own so it stays off the select path
            fix_r <= fixNext_s;
        end else if ((state_r == FIX) && !abort && fixPhase_r) begin
            result_r <= resultSel_s;
            rdOut_r  <= rd_r;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign rdOut  = rdOut_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench: a table of directed vectors, randomized operations
// checked against a plain-arithmetic RV32M model, and hand-written sequences
// for busy/abort/back-to-back/reset corner cases.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] opA   = 32'd0;
    logic [31:0] opB   = 32'd0;
    logic [4:0]  rdIn  = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdOut;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .rdIn   (rdIn),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rdOut  (rdOut)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.b   = b;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Reference RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int si, sj;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        si  = $signed(a);
        sj  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (ovf) return 32'h8000_0000;
                else return si / sj;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                else if (ovf) return 32'd0;
                else return si % sj;
            end
            3'd7: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        int s;
        s = $urandom_range(0, 9);
        case (s)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Present a request for one cycle; returns at start edge + 1ns
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        op    = o;
        opA   = a;
        opB   = b;
        rdIn  = rd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded
    task automatic waitDone(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic countDones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    task automatic runOne(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] e);
        int cyc;
        bit seen;
        issue(o, a, b, rd);
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        waitDone(cyc, seen);
        check({name, " latency"}, cyc, LAT);
        check({name, " result"}, result, e);
        check({name, " rdOut"}, {27'd0, rdOut}, {27'd0, rd});
        @(posedge clk);
        #1;
        check({name, " done width"}, {31'd0, done}, 32'd0);
        check({name, " result held"}, result, e);
    endtask

    initial begin
        int cyc;
        int cnt;
        bit seen;
        logic [2:0]  o;
        logic [31:0] a, b;

        // Reset state
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rdOut", {27'd0, rdOut}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        addVec(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        addVec(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        addVec(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        addVec(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        addVec(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        addVec(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        addVec(3'd5, 32'h10,        32'd0,         32'hFFFF_FFFF);
        addVec(3'd6, 32'h10,        32'd0,         32'h10);
        addVec(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        addVec(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        addVec(3'd7, 32'h10,        32'd0,         32'h10);
        addVec(3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
        addVec(3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1);
        addVec(3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF);
        addVec(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        for (int i = 0; i < vecs.size(); i++) begin
            runOne($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i),
                   vecs[i].exp);
        end

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pickOperand();
            b = pickOperand();
            runOne($sformatf("rand%0d op%0d a%08h b%08h", i, o, a, b), o, a, b,
                   5'($urandom_range(0, 31)), model(o, a, b));
        end

        // start while busy is ignored
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        repeat (5) @(posedge clk);
        #1;
        op    = 3'd5;
        opA   = 32'd100;
        opB   = 32'd3;
        rdIn  = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(cyc, seen);
        check("busy-start latency", cyc, LAT - 6);
        check("busy-start result", result, 32'hFFFF_FFEB);
        check("busy-start rdOut", {27'd0, rdOut}, 32'd5);
        countDones(LAT + 10, cnt);
        check("busy-start no queued op", cnt, 32'd0);

        // abort in CALC
        issue(3'd0, 32'd123, 32'd456, 5'd3);
        repeat (10) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        countDones(LAT + 10, cnt);
        check("abort no done", cnt, 32'd0);
        check("abort result kept", result, 32'hFFFF_FFEB);
        check("abort rdOut kept", {27'd0, rdOut}, 32'd5);

        // Back-to-back: second start in the DONE cycle
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1);
        waitDone(cyc, seen);
        check("b2b first latency", cyc, LAT);
        check("b2b first result", result, 32'hFFFF_FFFD);
        op    = 3'd6;
        opA   = 32'hFFFF_FFF9;
        opB   = 32'd2;
        rdIn  = 5'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b done low", {31'd0, done}, 32'd0);
        waitDone(cyc, seen);
        check("b2b second latency", cyc, LAT);
        check("b2b second result", result, 32'hFFFF_FFFF);
        check("b2b second rdOut", {27'd0, rdOut}, 32'd2);

        // abort together with start in IDLE
        repeat (2) @(posedge clk);
        @(negedge clk);
        op    = 3'd0;
        opA   = 32'd3;
        opB   = 32'd3;
        rdIn  = 5'd4;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("idle abort busy", {31'd0, busy}, 32'd0);
        countDones(LAT + 5, cnt);
        check("idle abort no done", cnt, 32'd0);

        // Asynchronous reset mid-CALC
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset done", {31'd0, done}, 32'd0);
        check("async reset result", result, 32'd0);
        check("async reset rdOut", {27'd0, rdOut}, 32'd0);
        rst_n = 1'b1;
        countDones(LAT + 10, cnt);
        check("reset no done", cnt, 32'd0);
        check("reset result stays", result, 32'd0);
        runOne("after reset", 3'd0, 32'd12, 32'd11, 5'd31, 32'd132);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
